// File: rtl/pulse_widen_mc.sv
// Multi-channel pulse widener: each channel stretches input pulses to a
// programmable width (edge mode) or extends a level past its fall (level mode).
module pulse_widen_mc #(
  parameter int CH          = 4,
  parameter int CNT_W       = 8,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    in,
  input  logic [CNT_W-1:0] width,
  input  logic             retrig,
  input  logic             drop_clr,
  output logic [CH-1:0]    out,
  output logic             busy,
  output logic [CH-1:0]    dropped
);

  logic [CH-1:0] s;
  logic [CH-1:0] in_d_reg;
  logic [CH-1:0] rise;
  logic [CH-1:0] set_drop;
  logic [CH-1:0] active_next;
  logic [CH-1:0] out_reg;
  logic          busy_reg;
  logic [CH-1:0] dropped_reg;
  logic [CH-1:0] dropped_next;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = in;
    end else begin : g_sync
      logic [CH-1:0] sync_reg [SYNC_STAGES];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
        end else begin
          sync_reg[0] <= in;
          for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
        end
      end
      assign s = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  assign rise = s & ~in_d_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             drop_here;

      always_comb begin
        cnt_next  = (cnt_reg != '0) ? cnt_reg - 1'b1 : '0;
        drop_here = 1'b0;
        if (MODE == 1) begin
          if (s[gi]) cnt_next = width;
        end else if (rise[gi]) begin
          // A busy channel only reloads when retriggering is allowed
          if (cnt_reg == '0 || retrig) cnt_next = width;
          else                         drop_here = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_reg <= '0;
        else     cnt_reg <= cnt_next;
      end

      assign active_next[gi] = (cnt_next != '0);
      assign set_drop[gi]    = drop_here;
    end
  endgenerate

  // New drops win over a simultaneous clear
  assign dropped_next = drop_clr ? set_drop : (dropped_reg | set_drop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_d_reg    <= '0;
      out_reg     <= '0;
      busy_reg    <= 1'b0;
      dropped_reg <= '0;
    end else begin
      in_d_reg    <= s;
      out_reg     <= active_next;
      busy_reg    <= |active_next;
      dropped_reg <= dropped_next;
    end
  end

  assign out     = out_reg;
  assign busy    = busy_reg;
  assign dropped = dropped_reg;

endmodule

// File: tb/tb_pulse_widen_mc.sv
// Bench for pulse_widen_mc: three instances (edge, level, edge+2-stage sync)
// compared every cycle against an end-time reference model.
module tb_pulse_widen_mc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_r = '0;
  logic [3:0] width_r = 4'd4;
  logic       retrig_r = 1'b0;
  logic       drop_clr_r = 1'b0;

  logic [2:0] d_out  [3];
  logic       d_busy [3];
  logic [2:0] d_drop [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pulse_widen_mc #(.CH(3), .CNT_W(4), .MODE(0), .SYNC_STAGES(0)) u_edge (
    .clk(clk), .rst(rst), .in(in_r), .width(width_r), .retrig(retrig_r),
    .drop_clr(drop_clr_r), .out(d_out[0]), .busy(d_busy[0]), .dropped(d_drop[0]));

  pulse_widen_mc #(.CH(3), .CNT_W(4), .MODE(1), .SYNC_STAGES(0)) u_lvl (
    .clk(clk), .rst(rst), .in(in_r), .width(width_r), .retrig(retrig_r),
    .drop_clr(drop_clr_r), .out(d_out[1]), .busy(d_busy[1]), .dropped(d_drop[1]));

  pulse_widen_mc #(.CH(3), .CNT_W(4), .MODE(0), .SYNC_STAGES(2)) u_sync (
    .clk(clk), .rst(rst), .in(in_r), .width(width_r), .retrig(retrig_r),
    .drop_clr(drop_clr_r), .out(d_out[2]), .busy(d_busy[2]), .dropped(d_drop[2]));

  // Reference model: each channel keeps the edge index at which its pulse ends.
  // out after edge t is high iff t < end_t.
  int         t = 0;
  int         end_t [3][3];
  logic [2:0] ind_m [3];
  logic [2:0] pipe_m [3][2];
  logic [2:0] e_out [3];
  logic       e_busy [3];
  logic [2:0] e_drop [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < 3; c++) end_t[k][c] = 0;
        ind_m[k] = '0; pipe_m[k][0] = '0; pipe_m[k][1] = '0;
        e_out[k] = '0; e_busy[k] = 1'b0; e_drop[k] = '0;
      end
    end else begin
      t++;
      for (int k = 0; k < 3; k++) begin
        logic [2:0] sv;
        logic [2:0] setd;
        sv = (k == 2) ? pipe_m[k][1] : in_r;
        pipe_m[k][1] = pipe_m[k][0];
        pipe_m[k][0] = in_r;
        setd = '0;
        for (int c = 0; c < 3; c++) begin
          if (k == 1) begin
            if (sv[c]) end_t[k][c] = t + int'(width_r);
          end else if (sv[c] && !ind_m[k][c]) begin
            if (!(t - 1 < end_t[k][c]) || retrig_r) end_t[k][c] = t + int'(width_r);
            else setd[c] = 1'b1;
          end
          e_out[k][c] = (t < end_t[k][c]);
        end
        e_drop[k] = drop_clr_r ? setd : (e_drop[k] | setd);
        e_busy[k] = |e_out[k];
        ind_m[k]  = sv;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_r = '0; drop_clr_r = 1'b0;
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({d_out[k], d_busy[k], d_drop[k]} !== 7'b0) begin
          n_fail++;
          $display("FAIL reset inst%0d out=%b busy=%b dropped=%b required all 0",
                   k, d_out[k], d_busy[k], d_drop[k]);
        end
      end
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single_pulse();
    int hi = 0;
    width_r = 4'd4; retrig_r = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_r = (c == 0) ? 3'b001 : 3'b000;
      step();
      hi += int'(d_out[0][0]);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({d_out[k], d_busy[k], d_drop[k]} !== {e_out[k], e_busy[k], e_drop[k]}) begin
          n_fail++;
          $display("FAIL single_pulse inst%0d cyc%0d out=%b busy=%b dropped=%b expected %b %b %b",
                   k, c, d_out[k], d_busy[k], d_drop[k], e_out[k], e_busy[k], e_drop[k]);
        end
      end
    end
    n_checks++;
    if (hi !== 4) begin
      n_fail++;
      $display("FAIL single_pulse_len high=%0d required 4", hi);
    end
    idle(4);
  endtask

  task automatic test_drop();
    width_r = 4'd4; retrig_r = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_r       = (c == 0 || c == 2) ? 3'b010 : 3'b000;
      drop_clr_r = (c == 8);
      step();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({d_out[k], d_busy[k], d_drop[k]} !== {e_out[k], e_busy[k], e_drop[k]}) begin
          n_fail++;
          $display("FAIL drop inst%0d cyc%0d out=%b busy=%b dropped=%b expected %b %b %b",
                   k, c, d_out[k], d_busy[k], d_drop[k], e_out[k], e_busy[k], e_drop[k]);
        end
      end
      if (c == 2 || c == 8) begin
        n_checks++;
        if (d_drop[0][1] !== (c == 2)) begin
          n_fail++;
          $display("FAIL drop_flag cyc%0d dropped[1]=%b required %b", c, d_drop[0][1], (c == 2));
        end
      end
    end
    idle(4);
  endtask

  task automatic test_retrig();
    int hi = 0;
    width_r = 4'd4; retrig_r = 1'b1; drop_clr_r = 1'b1;
    step();
    drop_clr_r = 1'b0;
    idle(6);
    for (int c = 0; c < 10; c++) begin
      in_r = (c == 0 || c == 2 || c == 8) ? 3'b010 : 3'b000;
      step();
      if (c < 8) hi += int'(d_out[0][1]);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({d_out[k], d_busy[k], d_drop[k]} !== {e_out[k], e_busy[k], e_drop[k]}) begin
          n_fail++;
          $display("FAIL retrig inst%0d cyc%0d out=%b busy=%b dropped=%b expected %b %b %b",
                   k, c, d_out[k], d_busy[k], d_drop[k], e_out[k], e_busy[k], e_drop[k]);
        end
      end
    end
    n_checks++;
    if (hi !== 6 || d_drop[0] !== 3'b000) begin
      n_fail++;
      $display("FAIL retrig_len high=%0d dropped=%b required 6 and 000", hi, d_drop[0]);
    end
    retrig_r = 1'b0;
    idle(8);
  endtask

  task automatic test_level();
    int hi = 0;
    width_r = 4'd3;
    for (int c = 0; c < 12; c++) begin
      in_r = (c < 5) ? 3'b100 : 3'b000;
      step();
      hi += int'(d_out[1][2]);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({d_out[k], d_busy[k], d_drop[k]} !== {e_out[k], e_busy[k], e_drop[k]}) begin
          n_fail++;
          $display("FAIL level inst%0d cyc%0d out=%b busy=%b dropped=%b expected %b %b %b",
                   k, c, d_out[k], d_busy[k], d_drop[k], e_out[k], e_busy[k], e_drop[k]);
        end
      end
    end
    n_checks++;
    if (hi !== 7) begin
      n_fail++;
      $display("FAIL level_len high=%0d required 7", hi);
    end
    idle(4);
  endtask

  task automatic test_width_zero();
    int hi = 0;
    width_r = 4'd0; drop_clr_r = 1'b1;
    step();
    drop_clr_r = 1'b0;
    for (int c = 0; c < 16; c++) begin
      in_r = 3'($urandom);
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({d_out[k], d_busy[k], d_drop[k]} !== 7'b0) begin
          n_fail++;
          $display("FAIL width_zero inst%0d out=%b busy=%b dropped=%b required all 0",
                   k, d_out[k], d_busy[k], d_drop[k]);
        end
      end
    end
    idle(4);
    width_r = 4'd4;
    for (int c = 0; c < 8; c++) begin
      in_r = (c == 0) ? 3'b001 : 3'b000;
      if (c == 1) width_r = 4'd9;
      step();
      hi += int'(d_out[0][0]);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({d_out[k], d_busy[k], d_drop[k]} !== {e_out[k], e_busy[k], e_drop[k]}) begin
          n_fail++;
          $display("FAIL width_change inst%0d cyc%0d out=%b busy=%b dropped=%b expected %b %b %b",
                   k, c, d_out[k], d_busy[k], d_drop[k], e_out[k], e_busy[k], e_drop[k]);
        end
      end
    end
    n_checks++;
    if (hi !== 4) begin
      n_fail++;
      $display("FAIL width_change_len high=%0d required 4", hi);
    end
    width_r = 4'd4;
    idle(12);
  endtask

  task automatic test_sync_reset();
    width_r = 4'd6;
    for (int c = 0; c < 4; c++) begin
      in_r = (c == 0) ? 3'b001 : 3'b000;
      step();
      n_checks++;
      if (d_out[2][0] !== (c >= 2)) begin
        n_fail++;
        $display("FAIL sync_latency cyc%0d out[0]=%b required %b", c, d_out[2][0], (c >= 2));
      end
    end
    // Mid-cycle reset must clear outputs without waiting for a clock edge
    in_r = 3'b011;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({d_out[k], d_busy[k], d_drop[k]} !== 7'b0) begin
        n_fail++;
        $display("FAIL async_reset inst%0d out=%b busy=%b dropped=%b required all 0",
                 k, d_out[k], d_busy[k], d_drop[k]);
      end
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({d_out[k], d_busy[k], d_drop[k]} !== {e_out[k], e_busy[k], e_drop[k]}) begin
          n_fail++;
          $display("FAIL held_release inst%0d cyc%0d out=%b busy=%b dropped=%b expected %b %b %b",
                   k, c, d_out[k], d_busy[k], d_drop[k], e_out[k], e_busy[k], e_drop[k]);
        end
      end
      if (c == 0) begin
        n_checks++;
        if (d_out[0][1:0] !== 2'b11) begin
          n_fail++;
          $display("FAIL held_release_first out[1:0]=%b required 11", d_out[0][1:0]);
        end
      end
    end
    idle(10);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_r       = 3'($urandom) & 3'($urandom);
      width_r    = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      retrig_r   = 1'($urandom);
      drop_clr_r = ($urandom_range(0, 9) == 0);
      step();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({d_out[k], d_busy[k], d_drop[k]} !== {e_out[k], e_busy[k], e_drop[k]}) begin
          n_fail++;
          $display("FAIL random inst%0d cyc%0d out=%b busy=%b dropped=%b expected %b %b %b",
                   k, c, d_out[k], d_busy[k], d_drop[k], e_out[k], e_busy[k], e_drop[k]);
        end
      end
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_drop();
    test_retrig();
    test_level();
    test_width_zero();
    test_sync_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
